// File: rtl/sseg_serial_driver.sv
// ---------------------------------------------------------------------------
// sseg_serial_driver
//
// Serial driver for an N-digit 7-segment display sitting behind an external
// shift-register chain. Each frame decodes the packed hex nibbles into
// active-low segment bytes, applies point/blank/blink control, shifts the
// 8*DIGITS-bit frame out MSB first on sclk/sout and then strobes EN so the
// chain latches it. Requests come from start or from a free-running refresh
// timer; a request arriving while a frame is in flight is held in a one-deep
// pending flag.
//
// Ports
//   clk      in   system clock, all logic on the rising edge
//   rstn     in   asynchronous active-low reset
//   start    in   request one frame (level sampled every clk)
//   auto_en  in   1 = self-trigger a frame every REFRESH_CYC cycles
//   hexs     in   digit i value = hexs[4i+3:4i]
//   points   in   1 = light the decimal point of digit i
//   LEs      in   1 = blank digit i
//   blink    in   1 = blank digit i while the blink phase is 1
//   sclk     out  shift clock to the chain, idle low
//   sclrn    out  active-low clear to the chain, high from the first edge
//                 after reset release
//   sout     out  serial data, stable around the sclk rising edge
//   EN       out  latch strobe, one sclk period after the last bit
//   busy     out  frame in progress
//   done     out  one-cycle pulse in the first idle cycle after a frame
// ---------------------------------------------------------------------------
module sseg_serial_driver #(
    parameter int DIGITS      = 8,
    parameter int CLK_DIV     = 2,
    parameter int REFRESH_CYC = 50000,
    parameter int BLINK_CYC   = 25000000
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                start,
    input  logic                auto_en,
    input  logic [4*DIGITS-1:0] hexs,
    input  logic [DIGITS-1:0]   points,
    input  logic [DIGITS-1:0]   LEs,
    input  logic [DIGITS-1:0]   blink,
    output logic                sclk,
    output logic                sclrn,
    output logic                sout,
    output logic                EN,
    output logic                busy,
    output logic                done
);

    localparam int N       = 8 * DIGITS;
    localparam int BIT_CYC = 2 * CLK_DIV;
    localparam int CW      = $clog2(BIT_CYC);
    localparam int BITW    = $clog2(N);
    localparam int RW      = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;
    localparam int BW      = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_LATCH
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;        // cycle within a bit / within LATCH
    logic [BITW-1:0] bit_q, bit_d;        // index of the bit on the wire
    logic [N-1:0]    frame_q, frame_d;    // MSB is always the bit on sout
    logic [N-1:0]    frame_load;
    logic            pending_q, pending_d;
    logic [RW-1:0]   ref_cnt_q;
    logic [BW-1:0]   blink_cnt_q;
    logic            blink_phase_q;
    logic            refresh_tick;

    logic sclk_q, sclk_d;
    logic sout_q, sout_d;
    logic en_q, en_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic sclrn_q;

    // Active-low segment pattern {dp,g,f,e,d,c,b,a}; dp is always off here.
    function automatic logic [7:0] seg_decode(input logic [3:0] h);
        logic [7:0] s;
        s = 8'hFF;
        case (h)
            4'h0: s = 8'hC0;  4'h1: s = 8'hF9;  4'h2: s = 8'hA4;  4'h3: s = 8'hB0;
            4'h4: s = 8'h99;  4'h5: s = 8'h92;  4'h6: s = 8'h82;  4'h7: s = 8'hF8;
            4'h8: s = 8'h80;  4'h9: s = 8'h90;  4'hA: s = 8'h88;  4'hB: s = 8'h83;
            4'hC: s = 8'hC6;  4'hD: s = 8'hA1;  4'hE: s = 8'h86;  4'hF: s = 8'h8E;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    // Digit i lands in frame bits [8i+7:8i], so digit DIGITS-1 leaves first.
    // Blanking wins over the decimal point.
    always_comb begin
        frame_load = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (LEs[i] || (blink[i] && blink_phase_q))
                frame_load[8*i +: 8] = 8'hFF;
            else
                frame_load[8*i +: 8] = seg_decode(hexs[4*i +: 4]) & {~points[i], 7'h7F};
        end
    end

    assign refresh_tick = (ref_cnt_q == RW'(REFRESH_CYC - 1));

    // Every request (start, or an enabled refresh tick) lands in the pending
    // flag; IDLE acts on the flag. This gives the one-cycle request latency
    // and the one-deep queue with a single mechanism. A request on the very
    // edge that enters LOAD is kept, as the frame it would join is already
    // being sampled.
    always_comb begin
        pending_d = pending_q;
        if (state_q == ST_IDLE && state_d == ST_LOAD)
            pending_d = 1'b0;
        if (start || (refresh_tick && auto_en))
            pending_d = 1'b1;
    end

    // Next-state logic.
    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        frame_d = frame_q;
        case (state_q)
            ST_IDLE: begin
                if (pending_q)
                    state_d = ST_LOAD;
            end
            ST_LOAD: begin
                frame_d = frame_load;
                cnt_d   = '0;
                bit_d   = '0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (cnt_q == CW'(BIT_CYC - 1)) begin
                    cnt_d = '0;
                    if (bit_q == BITW'(N - 1)) begin
                        state_d = ST_LATCH;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        frame_d = {frame_q[N-2:0], 1'b0};
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_LATCH: begin
                if (cnt_q == CW'(BIT_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they change
    // in step with the state and reach the pins glitch-free.
    always_comb begin
        sclk_d = (state_d == ST_SHIFT) && (cnt_d >= CW'(CLK_DIV));
        sout_d = (state_d == ST_SHIFT) && frame_d[N-1];
        en_d   = (state_d == ST_LATCH);
        busy_d = (state_d != ST_IDLE);
        done_d = (state_q == ST_LATCH) && (state_d == ST_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            bit_q         <= '0;
            frame_q       <= '0;
            pending_q     <= 1'b0;
            ref_cnt_q     <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            sclk_q        <= 1'b0;
            sout_q        <= 1'b0;
            en_q          <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            sclrn_q       <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            frame_q   <= frame_d;
            pending_q <= pending_d;
            ref_cnt_q <= refresh_tick ? '0 : ref_cnt_q + 1'b1;
            if (blink_cnt_q == BW'(BLINK_CYC - 1)) begin
                blink_cnt_q   <= '0;
                blink_phase_q <= ~blink_phase_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + 1'b1;
            end
            sclk_q  <= sclk_d;
            sout_q  <= sout_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sclrn_q <= 1'b1;
        end
    end

    assign sclk  = sclk_q;
    assign sout  = sout_q;
    assign EN    = en_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign sclrn = sclrn_q;

endmodule

// File: tb/tb_sseg_serial_driver.sv
// ---------------------------------------------------------------------------
// tb_sseg_serial_driver
//
// Bench for sseg_serial_driver with DIGITS=8, CLK_DIV=2, REFRESH_CYC=300 and
// BLINK_CYC=600. Frames are captured off the serial pins (sout at each sclk
// rise) and compared with a frame built directly from the digit rules.
// ---------------------------------------------------------------------------
module tb_sseg_serial_driver;

    localparam int DIGITS      = 8;
    localparam int CLK_DIV     = 2;
    localparam int REFRESH_CYC = 300;
    localparam int BLINK_CYC   = 600;
    localparam int N           = 8 * DIGITS;
    localparam int LAT         = 2 + 2 * CLK_DIV * (N + 1);   // start edge -> done cycle

    localparam logic [7:0] SEG_TAB [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic start = 1'b0;
    logic auto_en = 1'b0;
    logic [4*DIGITS-1:0] hexs = '0;
    logic [DIGITS-1:0] points = '0;
    logic [DIGITS-1:0] LEs = '0;
    logic [DIGITS-1:0] blink = '0;
    logic sclk, sclrn, sout, EN, busy, done;

    int errors = 0;
    int checks = 0;
    int edge_cnt;   // rising edges since reset release; value during cycle j is j

    sseg_serial_driver #(
        .DIGITS     (DIGITS),
        .CLK_DIV    (CLK_DIV),
        .REFRESH_CYC(REFRESH_CYC),
        .BLINK_CYC  (BLINK_CYC)
    ) dut (
        .clk    (clk),
        .rstn   (rstn),
        .start  (start),
        .auto_en(auto_en),
        .hexs   (hexs),
        .points (points),
        .LEs    (LEs),
        .blink  (blink),
        .sclk   (sclk),
        .sclrn  (sclrn),
        .sout   (sout),
        .EN     (EN),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) edge_cnt <= 0;
        else       edge_cnt <= edge_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference: the bit stream as sent, digit DIGITS-1 first, bit7 first.
    function automatic logic [N-1:0] model_frame(input logic [4*DIGITS-1:0] h,
                                                 input logic [DIGITS-1:0] p,
                                                 input logic [DIGITS-1:0] le,
                                                 input logic [DIGITS-1:0] bl,
                                                 input bit phase);
        logic [N-1:0] f;
        f = '0;
        for (int d = DIGITS - 1; d >= 0; d--) begin
            logic [7:0] b;
            if (le[d] || (bl[d] && phase)) begin
                b = 8'hFF;
            end else begin
                b = SEG_TAB[h[4*d +: 4]];
                if (p[d]) b[7] = 1'b0;
            end
            f = {f[N-9:0], b};
        end
        return f;
    endfunction

    // Blink phase seen by a frame whose sampling cycle is cycle e.
    function automatic bit phase_at(input int e);
        return ((e / BLINK_CYC) % 2) == 1;
    endfunction

    // Pulse start for one cycle; k is the edge that samples it.
    task automatic pulse_start(output int k);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = edge_cnt;
    endtask

    // Follow one frame from busy rising to done. Must be called at a negedge
    // while busy is low. inject=1 scrambles the inputs after bit 20;
    // inject=2 pulses start during bits 10 and 30.
    task automatic capture(input int inject, output logic [N-1:0] bits, output int nbits,
                           output int en_cyc, output int busy_edge, output int done_edge,
                           output bit overlap, output bit timeout);
        bit prev;
        int n;
        bits = '0; nbits = 0; en_cyc = 0; busy_edge = -1; done_edge = -1;
        overlap = 0; timeout = 0; prev = 0; n = 0;
        while (!busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!busy) begin
            timeout = 1;
            return;
        end
        busy_edge = edge_cnt;
        n = 0;
        while (!done && n < 400) begin
            if (inject == 2) start = 1'b0;
            if (sclk && !prev) begin
                bits = {bits[N-2:0], sout};
                nbits++;
                if (inject == 1 && nbits == 20) begin
                    hexs   = $urandom;
                    points = 8'($urandom);
                    LEs    = 8'($urandom);
                    blink  = 8'($urandom);
                end
                if (inject == 2 && (nbits == 10 || nbits == 30)) start = 1'b1;
            end
            if (EN) en_cyc++;
            if (EN && sclk) overlap = 1;
            prev = sclk;
            @(negedge clk);
            n++;
        end
        if (!done) begin
            timeout = 1;
            return;
        end
        done_edge = edge_cnt;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({sclk, sout, EN, busy, done, sclrn} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 000000", {sclk, sout, EN, busy, done, sclrn});
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({sclk, sout, EN, busy, done, sclrn} !== 6'b0) begin
            errors++;
            $display("FAIL reset_held: got %b expected 000000", {sclk, sout, EN, busy, done, sclrn});
        end
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if (sclrn !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: sclrn=%b busy=%b expected sclrn=1 busy=0", sclrn, busy);
        end
    endtask

    task automatic test_basic();
        logic [N-1:0] bits;
        int nb, en, be, de, k;
        bit ov, to;
        hexs = 32'h0123_4567; points = '0; LEs = '0; blink = '0;
        pulse_start(k);
        capture(0, bits, nb, en, be, de, ov, to);
        checks++;
        if (to) begin errors++; $display("FAIL basic_timeout: frame did not complete"); end
        checks++;
        if (nb !== N) begin errors++; $display("FAIL basic_bitcount: got %0d expected %0d", nb, N); end
        checks++;
        if (bits !== 64'hC0F9_A4B0_9992_82F8) begin
            errors++; $display("FAIL basic_frame: got %h expected c0f9a4b0999282f8", bits);
        end
        checks++;
        if (en !== 2 * CLK_DIV || ov) begin
            errors++; $display("FAIL basic_en: en_cycles=%0d overlap=%0d expected %0d and 0", en, ov, 2 * CLK_DIV);
        end
        checks++;
        if (be !== k + 1) begin errors++; $display("FAIL basic_busy_start: got %0d expected %0d", be, k + 1); end
        checks++;
        if (de !== k + LAT) begin errors++; $display("FAIL basic_done_time: got %0d expected %0d", de, k + LAT); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done: got %b expected 0", busy); end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL basic_after: busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_freeze();
        logic [N-1:0] bits, exp;
        int nb, en, be, de, k;
        bit ov, to;
        hexs = 32'hFFFF_FFF8; points = 8'h01; LEs = 8'h80; blink = '0;
        exp = model_frame(hexs, points, LEs, blink, 1'b0);
        pulse_start(k);
        capture(1, bits, nb, en, be, de, ov, to);
        checks++;
        if (to || bits !== exp) begin
            errors++; $display("FAIL freeze_frame: got %h expected %h timeout=%0d", bits, exp, to);
        end
        checks++;
        if (bits[N-1 -: 8] !== 8'hFF || bits[7:0] !== 8'h00) begin
            errors++; $display("FAIL freeze_ends: first=%h last=%h expected ff 00", bits[N-1 -: 8], bits[7:0]);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] bits, exp;
        int nb, en, be, de, k;
        bit ov, to;
        for (int f = 0; f < 4; f++) begin
            hexs   = $urandom;
            points = 8'($urandom);
            LEs    = 8'($urandom) & 8'($urandom);
            blink  = 8'($urandom);
            pulse_start(k);
            capture(0, bits, nb, en, be, de, ov, to);
            exp = model_frame(hexs, points, LEs, blink, phase_at(be));
            checks++;
            if (to || bits !== exp) begin
                errors++; $display("FAIL random_frame[%0d]: got %h expected %h timeout=%0d", f, bits, exp, to);
            end
            checks++;
            if (de !== k + LAT) begin
                errors++; $display("FAIL random_latency[%0d]: got %0d expected %0d", f, de, k + LAT);
            end
            checks++;
            if (en !== 2 * CLK_DIV || ov) begin
                errors++; $display("FAIL random_en[%0d]: en_cycles=%0d overlap=%0d", f, en, ov);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] bits1, bits2, exp;
        int nb, en, be1, de1, be2, de2, k, extra;
        bit ov, to1, to2;
        hexs = $urandom; points = 8'($urandom); LEs = '0; blink = '0;
        exp = model_frame(hexs, points, LEs, blink, 1'b0);
        pulse_start(k);
        capture(2, bits1, nb, en, be1, de1, ov, to1);
        start = 1'b0;
        capture(0, bits2, nb, en, be2, de2, ov, to2);
        checks++;
        if (to1 || to2) begin
            errors++; $display("FAIL b2b_timeout: first=%0d second=%0d expected 0 0", to1, to2);
        end
        checks++;
        if (be2 !== de1 + 1) begin
            errors++; $display("FAIL b2b_queued_start: got %0d expected %0d", be2, de1 + 1);
        end
        checks++;
        if (bits1 !== exp || bits2 !== exp) begin
            errors++; $display("FAIL b2b_frames: got %h / %h expected %h", bits1, bits2, exp);
        end
        checks++;
        if (de2 !== be2 + LAT - 1) begin
            errors++; $display("FAIL b2b_second_done: got %0d expected %0d", de2, be2 + LAT - 1);
        end
        extra = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (busy || done) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++; $display("FAIL b2b_extra_frame: busy/done cycles=%0d expected 0", extra);
        end
    endtask

    task automatic test_auto();
        logic [N-1:0] bits [3];
        logic [N-1:0] exp;
        int be [3];
        int nb, en, de;
        bit ov, to;
        hexs = $urandom; points = 8'($urandom); LEs = '0; blink = 8'h01;
        @(negedge clk);
        auto_en = 1'b1;
        for (int f = 0; f < 3; f++) begin
            capture(0, bits[f], nb, en, be[f], de, ov, to);
            exp = model_frame(hexs, points, LEs, blink, phase_at(be[f]));
            checks++;
            if (to || bits[f] !== exp) begin
                errors++; $display("FAIL auto_frame[%0d]: got %h expected %h timeout=%0d", f, bits[f], exp, to);
            end
        end
        auto_en = 1'b0;
        checks++;
        if (be[1] - be[0] !== REFRESH_CYC || be[2] - be[1] !== REFRESH_CYC) begin
            errors++; $display("FAIL auto_period: got %0d %0d expected %0d", be[1] - be[0], be[2] - be[1], REFRESH_CYC);
        end
        checks++;
        if ((bits[0][7:0] == 8'hFF) == (bits[1][7:0] == 8'hFF)) begin
            errors++; $display("FAIL auto_blink_alternate: digit0 got %h then %h expected one ff", bits[0][7:0], bits[1][7:0]);
        end
    endtask

    task automatic test_mid_reset();
        logic [N-1:0] bits, exp;
        int nb, en, be, de, k, n, cnt;
        bit ov, to, prev, bad;
        repeat (300) @(negedge clk);   // let any pending refresh work drain
        hexs = $urandom; points = 8'($urandom); LEs = '0; blink = '0;
        pulse_start(k);
        n = 0; cnt = 0; prev = 0;
        while (cnt < 20 && n < 300) begin
            @(negedge clk);
            n++;
            if (sclk && !prev) cnt++;
            prev = sclk;
        end
        checks++;
        if (cnt !== 20) begin errors++; $display("FAIL midreset_reach_bit20: got %0d bits", cnt); end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if ({sclk, sout, EN, busy, done, sclrn} !== 6'b0) begin
            errors++; $display("FAIL midreset_immediate: got %b expected 000000", {sclk, sout, EN, busy, done, sclrn});
        end
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if ({sclk, sout, EN, busy, done, sclrn} !== 6'b0) bad = 1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL midreset_held: outputs left reset state, expected 000000"); end
        rstn = 1'b1;
        bad = 0;
        @(negedge clk);
        checks++;
        if (sclrn !== 1'b1 || EN !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL midreset_release: sclrn=%b EN=%b busy=%b expected 1 0 0", sclrn, EN, busy);
        end
        hexs = $urandom; points = 8'($urandom); LEs = 8'($urandom) & 8'($urandom); blink = '0;
        exp = model_frame(hexs, points, LEs, blink, 1'b0);
        pulse_start(k);
        capture(0, bits, nb, en, be, de, ov, to);
        checks++;
        if (to || bits !== exp || nb !== N) begin
            errors++; $display("FAIL midreset_new_frame: got %h (%0d bits) expected %h", bits, nb, exp);
        end
        checks++;
        if (de !== k + LAT || en !== 2 * CLK_DIV) begin
            errors++; $display("FAIL midreset_new_timing: done=%0d en=%0d expected %0d %0d", de, en, k + LAT, 2 * CLK_DIV);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_freeze();
        test_random();
        test_back_to_back();
        test_auto();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
